// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int LANE_W    = 8;
  localparam int LANES     = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;
endpackage

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port,
// one combinational read port.
module imem_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction store.
// Holds the CPU in reset until a load completes.
module imem_loader
  import imem_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic [31:0]       addr,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err
);
  state_e              state_q, state_d;
  logic [1:0]          byte_q, byte_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [23:0]         buf_q, buf_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;
  logic                we;
  logic                unused_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    hold_d  = hold_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0 &&
              word_cnt <= (ADDR_W+1)'(DEPTH)) begin
            state_d = LOAD;
            cnt_d   = word_cnt;
            byte_d  = '0;
            word_d  = '0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          byte_d = byte_q + 2'd1;
          if (byte_q != 2'(LANES - 1)) begin
            buf_d[LANE_W*byte_q +: LANE_W] = s_data;
          end else begin
            we = 1'b1;
            // last word of the program releases the CPU
            if ({1'b0, word_q} == cnt_q - (ADDR_W+1)'(1)) begin
              state_d = DONE;
              hold_d  = 1'b0;
            end else begin
              word_d = word_q + ADDR_W'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (word_q),
    .wdata ({s_data, buf_q}),
    .raddr (addr[ADDR_W+1:2]),
    .rdata (rdata)
  );

  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign s_ready  = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign cpu_hold = hold_q;
  assign err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-count
// based reference model and per-cycle output compare.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  word_cnt;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        busy, done, cpu_hold, err;

  int nchk = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .word_cnt (word_cnt),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .addr     (addr),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold),
    .err      (err)
  );

  always #5 clk = ~clk;

  // model: counts total accepted bytes of the current program
  int          m_mode;
  int          m_cnt;
  int          m_nb;
  logic        m_hold, m_err;
  logic [7:0]  m_bytes [64];
  logic [31:0] m_mem [16];
  logic        m_known [16];

  initial for (int i = 0; i < 16; i++) m_known[i] = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
      m_hold <= 1'b1;
      m_err  <= 1'b0;
      m_nb   <= 0;
    end else if (m_mode == 0) begin
      if (start) begin
        if (word_cnt >= 1 && word_cnt <= 16) begin
          m_mode <= 1;
          m_cnt  <= int'(word_cnt);
          m_nb   <= 0;
          m_err  <= 1'b0;
          m_hold <= 1'b1;
        end else begin
          m_err <= 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (s_valid) begin
        m_bytes[m_nb] <= s_data;
        m_nb <= m_nb + 1;
        if (m_nb % 4 == 3) begin
          m_mem[m_nb/4] <= {s_data, m_bytes[m_nb-1],
                            m_bytes[m_nb-2], m_bytes[m_nb-3]};
          m_known[m_nb/4] <= 1'b1;
          if (m_nb + 1 == 4 * m_cnt) begin
            m_mode <= 2;
            m_hold <= 1'b0;
          end
        end
      end
    end else begin
      m_mode <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      chk("s_ready", 32'(s_ready), 32'(m_mode == 1));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      chk("err", 32'(err), 32'(m_err));
      idx = int'(addr[5:2]);
      if (m_known[idx]) chk("rdata", rdata, m_mem[idx]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    addr = $urandom;
  endtask

  task automatic do_start(input logic [4:0] n);
    start    = 1'b1;
    word_cnt = n;
    step();
    start    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int gap_pct,
                      input int max, input bit noise);
    for (int i = 0; i < max; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid  = 1'b0;
        s_data   = 8'($urandom);
        start    = noise ? 1'($urandom) : 1'b0;
        word_cnt = 5'($urandom);
        step();
      end
      s_valid  = 1'b1;
      s_data   = b[i];
      start    = noise ? 1'($urandom) : 1'b0;
      word_cnt = 5'($urandom);
      step();
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  logic [7:0] prog [$];
  logic [7:0] prog2 [$];
  logic [7:0] prog3 [$];
  logic [7:0] rprog [$];

  initial begin
    reset = 1'b1; start = 1'b0; word_cnt = '0;
    s_valid = 1'b0; s_data = '0; addr = '0;
    prog  = '{8'h33, 8'h02, 8'h11, 8'h00,
              8'hB3, 8'h02, 8'h11, 8'h40};
    prog2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11};
    prog3 = '{8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk_en = 1'b1;
    step();

    // back-to-back R-type load
    do_start(5'd2);
    send(prog, 0, 8, 1'b0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("hold_rel", 32'(cpu_hold), 32'd0);
    rd("m0", 32'h0, 32'h00110233);
    rd("m1", 32'h4, 32'h401102B3);
    chk("model_m0", m_mem[0], 32'h00110233);
    chk("model_m1", m_mem[1], 32'h401102B3);
    step();
    chk("done_gone", 32'(done), 32'd0);
    chk("hold_idle", 32'(cpu_hold), 32'd0);
    rd("wrap44", 32'h44, 32'h401102B3);
    rd("wrap05", 32'h05, 32'h401102B3);

    // same load with gaps and ignored start pulses
    do_start(5'd2);
    chk("hold_reacq", 32'(cpu_hold), 32'd1);
    send(prog, 50, 8, 1'b1);
    chk("gap_done", 32'(done), 32'd1);
    rd("gap_m0", 32'h0, 32'h00110233);
    rd("gap_m1", 32'h4, 32'h401102B3);
    step();

    // illegal word counts
    do_start(5'd0);
    chk("err0", 32'(err), 32'd1);
    chk("err0_rdy", 32'(s_ready), 32'd0);
    chk("err0_hold", 32'(cpu_hold), 32'd0);
    do_start(5'd17);
    chk("err17", 32'(err), 32'd1);
    step();
    rd("err_m0", 32'h0, 32'h00110233);

    // legal start clears err, then reset mid-load
    do_start(5'd2);
    chk("err_clr", 32'(err), 32'd0);
    send(prog2, 20, 5, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    rd("mid_m0", 32'h0, 32'hDEADBEEF);
    rd("mid_m1", 32'h4, 32'h401102B3);
    step();
    do_start(5'd2);
    send(prog3, 30, 8, 1'b0);
    rd("rl_m0", 32'h0, 32'h00100513);
    rd("rl_m1", 32'h4, 32'h00200593);
    step();

    // randomized loads, some with illegal counts first
    for (int k = 0; k < 8; k++) begin
      int n;
      if ($urandom_range(2) == 0)
        do_start(($urandom_range(1) == 0) ? 5'd0
                 : 5'($urandom_range(31, 17)));
      n = $urandom_range(16, 1);
      rprog.delete();
      for (int j = 0; j < 4 * n; j++) rprog.push_back(8'($urandom));
      do_start(5'(n));
      send(rprog, $urandom_range(60), 4 * n, 1'b1);
      chk("rnd_done", 32'(done), 32'd1);
      repeat (3) step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
